// File: rtl/serial_tx_pkg.sv
// serial_pkg: definitions shared by the serial transmitter and its matching receiver.
//   state_e   - 2-bit frame FSM encoding (IDLE/START/DATA/STOP)
//   START_LVL - line level of the start bit
//   STOP_LVL  - line level of the stop bit (also the idle level)
//   cnt_w()   - counter width for values 0..n-1, never below 1 bit
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_tx_if.sv
// serial_tx_if: valid/ready word handshake into the serial transmitter.
//   in_data  - word to transmit (source -> transmitter)
//   in_valid - source has a word (source -> transmitter)
//   in_ready - transmitter can accept (transmitter -> source)
interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/serial_tx_bit_timer.sv
// bit_timer: free-running 0..CLKS_PER_BIT-1 counter producing one tick per serial bit.
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   clr  - synchronous clear back to 0
//   tick - high while the count sits at CLKS_PER_BIT-1 (every cycle when CLKS_PER_BIT=1)
module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            TW   = cnt_w(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_cnt <= '0;
    else if (clr || tick)  r_cnt <= '0;
    else                   r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out frame transmitter.
// Frame = start bit, DATA_W data bits LSB first, stop bit; each bit held CLKS_PER_BIT clocks.
//   clk   - system clock
//   rst   - asynchronous active-high reset (aborts any frame, line goes high)
//   in_if - valid/ready word input (slave side)
//   sout  - registered serial line, idles high
//   busy  - frame in progress
//   done  - one-cycle pulse in the first IDLE cycle after a frame
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  serial_tx_if.slave        in_if,
  output logic              sout,
  output logic              busy,
  output logic              done
);

  localparam int             BCW      = cnt_w(DATA_W);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  state_e            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
  logic [BCW-1:0]    r_bitcnt, w_bitcnt_nxt;
  logic              r_sout, w_sout_nxt;
  logic              r_done, w_done_nxt;
  logic              w_idle, w_accept, w_tick, w_clr;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && in_if.in_valid;
  // Held clear through IDLE so the first START bit gets a full bit period.
  assign w_clr    = w_idle || (w_state_nxt != r_state);

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    w_done_nxt   = 1'b0;
    w_sout_nxt   = STOP_LVL;

    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt  = ST_START;
          w_shreg_nxt  = in_if.in_data;
          w_bitcnt_nxt = '0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt  = ST_DATA;
          w_bitcnt_nxt = '0;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bitcnt == LAST_BIT) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_shreg_nxt  = r_shreg >> 1;
            w_bitcnt_nxt = r_bitcnt + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Line level is registered from the next state so it changes on the same edge as the FSM.
    unique case (w_state_nxt)
      ST_START: w_sout_nxt = START_LVL;
      ST_DATA:  w_sout_nxt = w_shreg_nxt[0];
      default:  w_sout_nxt = STOP_LVL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_sout   <= STOP_LVL;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_sout   <= w_sout_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign sout           = r_sout;
  assign done           = r_done;
  assign busy           = !w_idle;
  assign in_if.in_ready = w_idle;

endmodule
